mouse_packet_assembler: RTL and testbench

- Sits directly downstream of the PS/2 MouseReceiver; consumes its byte stream (byte, error code, ready strobe) and drives its READ_ENABLE.
- Frames 3-byte PS/2 stream-mode packets as status, dX, dY, and rejects bad or misaligned packets.
- Keeps clamped absolute X/Y cursor positions for the display and LED logic further down the design.

---
 rtl/mouse_packet_assembler.sv | 148 ++++++++++++++
 tb/tb_mouse_packet_assembler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_packet_assembler.sv
// Frames 3-byte PS/2 mouse packets and tracks clamped absolute cursor X/Y.
// Optional MOUSE_ACCEL_EN doubles large deltas before the position clamp.
module mouse_packet_assembler #(
    parameter int X_MAX          = 160,
    parameter int Y_MAX          = 120,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ACCEL_THRESH   = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic       READ_ENABLE,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic [7:0] MOUSE_X,
    output logic [7:0] MOUSE_Y,
    output logic       PACKET_VALID,
    output logic       PACKET_ERROR
);

    // state   | meaning
    // WAIT_B1 | waiting for a status byte (bit3 set), stray bytes dropped
    // WAIT_B2 | waiting for dX, inter-byte timeout running
    // WAIT_B3 | waiting for dY, inter-byte timeout running
    // UPDATE  | receiver held off while outputs and position are applied
    typedef enum logic [1:0] {WAIT_B1, WAIT_B2, WAIT_B3, UPDATE} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef MOUSE_ACCEL_EN
    localparam int SUM_W = 12;
`else
    localparam int SUM_W = 10;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       status_q;
    logic [7:0]       dx_q;
    logic [7:0]       dy_q;
    logic [7:0]       next_x;
    logic [7:0]       next_y;

    function automatic logic signed [SUM_W-1:0] scale_delta(input logic sign_bit,
                                                             input logic [7:0] raw,
                                                             input logic ovf);
        logic signed [SUM_W-1:0] ext;
        logic [8:0]              mag;
        ext = ovf ? '0 : {{(SUM_W-8){sign_bit}}, raw};
        mag = sign_bit ? 9'(~{sign_bit, raw} + 9'd1) : {sign_bit, raw};
`ifdef MOUSE_ACCEL_EN
        if (!ovf && mag >= 9'(ACCEL_THRESH))
            ext = ext <<< 1;
`else
        if (mag == 9'd0) ext = '0;
`endif
        return ext;
    endfunction

    function automatic logic [7:0] clamp_pos(input logic [7:0] pos,
                                             input logic signed [SUM_W-1:0] delta,
                                             input int max);
        logic signed [SUM_W-1:0] sum;
        sum = $signed({{(SUM_W-8){1'b0}}, pos}) + delta;
        if (sum < 0)
            return 8'd0;
        if (sum > $signed(SUM_W'(max - 1)))
            return 8'(max - 1);
        return sum[7:0];
    endfunction

    always_comb begin
        next_x = clamp_pos(MOUSE_X, scale_delta(status_q[4], dx_q, status_q[6]), X_MAX);
        next_y = clamp_pos(MOUSE_Y, scale_delta(status_q[5], dy_q, status_q[7]), Y_MAX);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= WAIT_B1;
            cnt          <= '0;
            status_q     <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            READ_ENABLE  <= 1'b0;
            MOUSE_STATUS <= '0;
            MOUSE_DX     <= '0;
            MOUSE_DY     <= '0;
            MOUSE_X      <= 8'(X_MAX / 2);
            MOUSE_Y      <= 8'(Y_MAX / 2);
            PACKET_VALID <= 1'b0;
            PACKET_ERROR <= 1'b0;
        end else begin
            PACKET_VALID <= 1'b0;
            PACKET_ERROR <= 1'b0;
            READ_ENABLE  <= 1'b1;
            case (state)
                WAIT_B1: begin
                    cnt <= '0;
                    if (BYTE_READY) begin
                        if (BYTE_ERROR_CODE != 2'b00) begin
                            PACKET_ERROR <= 1'b1;
                        end else if (BYTE_READ[3]) begin
                            status_q <= BYTE_READ;
                            state    <= WAIT_B2;
                        end
                    end
                end
                WAIT_B2, WAIT_B3: begin
                    // A strobe in the terminal cycle takes priority over the timeout.
                    if (BYTE_READY) begin
                        cnt <= '0;
                        if (BYTE_ERROR_CODE != 2'b00) begin
                            PACKET_ERROR <= 1'b1;
                            state        <= WAIT_B1;
                        end else if (state == WAIT_B2) begin
                            dx_q  <= BYTE_READ;
                            state <= WAIT_B3;
                        end else begin
                            dy_q        <= BYTE_READ;
                            state       <= UPDATE;
                            READ_ENABLE <= 1'b0;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cnt          <= '0;
                        PACKET_ERROR <= 1'b1;
                        state        <= WAIT_B1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                UPDATE: begin
                    MOUSE_STATUS <= status_q;
                    MOUSE_DX     <= dx_q;
                    MOUSE_DY     <= dy_q;
                    MOUSE_X      <= next_x;
                    MOUSE_Y      <= next_y;
                    PACKET_VALID <= 1'b1;
                    cnt          <= '0;
                    state        <= WAIT_B1;
                end
                default: state <= WAIT_B1;
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_packet_assembler.sv
// Directed bench for mouse_packet_assembler with a shortened timeout of 50 cycles.
// Define MOUSE_ACCEL_EN for both DUT and bench to exercise the acceleration path.
module tb_mouse_packet_assembler;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] BYTE_READ = '0;
    logic [1:0] BYTE_ERROR_CODE = '0;
    logic       BYTE_READY = 1'b0;
    logic       READ_ENABLE;
    logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_X, MOUSE_Y;
    logic       PACKET_VALID, PACKET_ERROR;

    int vectors = 0;
    int miscompares = 0;
    int n_valid = 0;
    int n_error = 0;

    mouse_packet_assembler #(.TIMEOUT_CYCLES(50)) dut (
        .CLK(CLK), .RESET(RESET), .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY(BYTE_READY), .READ_ENABLE(READ_ENABLE), .MOUSE_STATUS(MOUSE_STATUS),
        .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY), .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y),
        .PACKET_VALID(PACKET_VALID), .PACKET_ERROR(PACKET_ERROR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (PACKET_VALID) n_valid++;
        if (PACKET_ERROR) n_error++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; the strobe is sampled by the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b, input logic [1:0] err);
        BYTE_READ = b;
        BYTE_ERROR_CODE = err;
        BYTE_READY = 1'b1;
        @(negedge CLK);
        BYTE_READY = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
    endtask

    // Returns in the cycle where PACKET_VALID should be high.
    task automatic pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
        send_byte(s, 2'b00);
        send_byte(x, 2'b00);
        send_byte(y, 2'b00);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        BYTE_READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (READ_ENABLE !== 1'b0 || PACKET_VALID !== 1'b0 || PACKET_ERROR !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got re=%b pv=%b pe=%b want 0 0 0", READ_ENABLE, PACKET_VALID, PACKET_ERROR);
        end
        vectors++;
        if (MOUSE_X !== 8'd80 || MOUSE_Y !== 8'd60) begin
            miscompares++;
            $display("FAIL reset_pos got x=%0d y=%0d want 80 60", MOUSE_X, MOUSE_Y);
        end
        vectors++;
        if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_bytes got %h want 000000", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
        end
        RESET = 1'b1;
        @(negedge CLK);
        vectors++;
        if (READ_ENABLE !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_re got %b want 1", READ_ENABLE);
        end
    endtask

    task automatic test_basic();
        int v0;
        v0 = n_valid;
        send_byte(8'h08, 2'b00);
        send_byte(8'h05, 2'b00);
        send_byte(8'h03, 2'b00);
        vectors++;
        if (READ_ENABLE !== 1'b0 || PACKET_VALID !== 1'b0 || MOUSE_X !== 8'd80) begin
            miscompares++;
            $display("FAIL basic_update_cycle got re=%b pv=%b x=%0d want 0 0 80", READ_ENABLE, PACKET_VALID, MOUSE_X);
        end
        @(negedge CLK);
        vectors++;
        if (PACKET_VALID !== 1'b1 || READ_ENABLE !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_valid got pv=%b re=%b want 1 1", PACKET_VALID, READ_ENABLE);
        end
        vectors++;
        if (MOUSE_X !== 8'd85 || MOUSE_Y !== 8'd63) begin
            miscompares++;
            $display("FAIL basic_pos got x=%0d y=%0d want 85 63", MOUSE_X, MOUSE_Y);
        end
        vectors++;
        if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h080503) begin
            miscompares++;
            $display("FAIL basic_bytes got %h want 080503", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
        end
        @(negedge CLK);
        vectors++;
        if (PACKET_VALID !== 1'b0 || n_valid - v0 != 1) begin
            miscompares++;
            $display("FAIL basic_pulse got pv=%b count=%0d want 0 1", PACKET_VALID, n_valid - v0);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        for (int i = 0; i < 7; i++) pkt(8'h18, 8'hF6, 8'h00);
        vectors++;
        if (MOUSE_X !== 8'd10) begin
            miscompares++;
            $display("FAIL clamp_x7 got %0d want 10", MOUSE_X);
        end
        for (int i = 0; i < 3; i++) pkt(8'h18, 8'hF6, 8'h00);
        vectors++;
        if (MOUSE_X !== 8'd0 || MOUSE_Y !== 8'd60) begin
            miscompares++;
            $display("FAIL clamp_xmin got x=%0d y=%0d want 0 60", MOUSE_X, MOUSE_Y);
        end
        pkt(8'h08, 8'hFF, 8'h00);
        pkt(8'h08, 8'hFF, 8'h00);
        vectors++;
        if (MOUSE_X !== 8'd159) begin
            miscompares++;
            $display("FAIL clamp_xmax got %0d want 159", MOUSE_X);
        end
        pkt(8'h08, 8'h00, 8'h7F);
        vectors++;
        if (MOUSE_Y !== 8'd119) begin
            miscompares++;
            $display("FAIL clamp_ymax got %0d want 119", MOUSE_Y);
        end
        pkt(8'h28, 8'h00, 8'h80);
        vectors++;
        if (MOUSE_Y !== 8'd0 || MOUSE_X !== 8'd159) begin
            miscompares++;
            $display("FAIL clamp_ymin got x=%0d y=%0d want 159 0", MOUSE_X, MOUSE_Y);
        end
    endtask

    task automatic test_byte_error();
        int e0;
        do_reset();
        e0 = n_error;
        send_byte(8'h08, 2'b00);
        send_byte(8'h05, 2'b01);
        vectors++;
        if (PACKET_ERROR !== 1'b1) begin
            miscompares++;
            $display("FAIL err_b2_pulse got %b want 1", PACKET_ERROR);
        end
        @(negedge CLK);
        vectors++;
        if (MOUSE_X !== 8'd80 || MOUSE_STATUS !== 8'h00 || n_error - e0 != 1) begin
            miscompares++;
            $display("FAIL err_b2_hold got x=%0d st=%h errs=%0d want 80 00 1", MOUSE_X, MOUSE_STATUS, n_error - e0);
        end
        pkt(8'h08, 8'h02, 8'h01);
        vectors++;
        if (PACKET_VALID !== 1'b1 || MOUSE_X !== 8'd82 || MOUSE_Y !== 8'd61) begin
            miscompares++;
            $display("FAIL err_recover got pv=%b x=%0d y=%0d want 1 82 61", PACKET_VALID, MOUSE_X, MOUSE_Y);
        end
        send_byte(8'h08, 2'b00);
        send_byte(8'h01, 2'b00);
        send_byte(8'h01, 2'b10);
        vectors++;
        if (PACKET_ERROR !== 1'b1) begin
            miscompares++;
            $display("FAIL err_b3_pulse got %b want 1", PACKET_ERROR);
        end
        @(negedge CLK);
        vectors++;
        if (MOUSE_X !== 8'd82 || PACKET_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL err_b3_hold got x=%0d pv=%b want 82 0", MOUSE_X, PACKET_VALID);
        end
    endtask

    task automatic test_sync();
        int e0;
        do_reset();
        e0 = n_error;
        send_byte(8'h00, 2'b00);
        pkt(8'h08, 8'h01, 8'h01);
        vectors++;
        if (MOUSE_X !== 8'd81 || MOUSE_Y !== 8'd61 || n_error != e0) begin
            miscompares++;
            $display("FAIL sync_stray got x=%0d y=%0d errs=%0d want 81 61 0", MOUSE_X, MOUSE_Y, n_error - e0);
        end
    endtask

    task automatic test_timeout();
        int seen;
        int e0;
        do_reset();
        e0 = n_error;
        seen = -1;
        send_byte(8'h08, 2'b00);
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (PACKET_ERROR === 1'b1 && seen < 0) seen = i;
        end
        vectors++;
        if (seen != 50 || n_error - e0 != 1) begin
            miscompares++;
            $display("FAIL timeout_cycle got at=%0d count=%0d want 50 1", seen, n_error - e0);
        end
        pkt(8'h08, 8'h04, 8'h00);
        vectors++;
        if (PACKET_VALID !== 1'b1 || MOUSE_X !== 8'd84 || MOUSE_STATUS !== 8'h08) begin
            miscompares++;
            $display("FAIL timeout_resync got pv=%b x=%0d st=%h want 1 84 08", PACKET_VALID, MOUSE_X, MOUSE_STATUS);
        end
        // Second byte lands exactly in the terminal-count cycle.
        e0 = n_error;
        send_byte(8'h08, 2'b00);
        repeat (49) @(negedge CLK);
        send_byte(8'h03, 2'b00);
        send_byte(8'h00, 2'b00);
        @(negedge CLK);
        vectors++;
        if (PACKET_VALID !== 1'b1 || MOUSE_X !== 8'd87 || n_error != e0) begin
            miscompares++;
            $display("FAIL timeout_byte_wins got pv=%b x=%0d errs=%0d want 1 87 0", PACKET_VALID, MOUSE_X, n_error - e0);
        end
    endtask

    task automatic test_update_ignore();
        do_reset();
        send_byte(8'h08, 2'b00);
        send_byte(8'h01, 2'b00);
        send_byte(8'h01, 2'b00);
        send_byte(8'h08, 2'b00);
        pkt(8'h08, 8'h02, 8'h02);
        vectors++;
        if (MOUSE_X !== 8'd83 || MOUSE_Y !== 8'd63) begin
            miscompares++;
            $display("FAIL update_ignore got x=%0d y=%0d want 83 63", MOUSE_X, MOUSE_Y);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        pkt(8'h48, 8'h7F, 8'h02);
        vectors++;
        if (MOUSE_X !== 8'd80 || MOUSE_Y !== 8'd62) begin
            miscompares++;
            $display("FAIL ovf_x got x=%0d y=%0d want 80 62", MOUSE_X, MOUSE_Y);
        end
        pkt(8'h88, 8'h03, 8'h7F);
        vectors++;
        if (MOUSE_X !== 8'd83 || MOUSE_Y !== 8'd62 || MOUSE_DY !== 8'h7F) begin
            miscompares++;
            $display("FAIL ovf_y got x=%0d y=%0d dy=%h want 83 62 7f", MOUSE_X, MOUSE_Y, MOUSE_DY);
        end
    endtask

    task automatic test_accel();
        int exp1, exp2, exp3;
`ifdef MOUSE_ACCEL_EN
        exp1 = 120; exp2 = 135; exp3 = 103;
`else
        exp1 = 100; exp2 = 115; exp3 = 99;
`endif
        do_reset();
        pkt(8'h08, 8'h14, 8'h00);
        vectors++;
        if (MOUSE_X !== 8'(exp1)) begin
            miscompares++;
            $display("FAIL accel_pos20 got %0d want %0d", MOUSE_X, exp1);
        end
        pkt(8'h08, 8'h0F, 8'h00);
        vectors++;
        if (MOUSE_X !== 8'(exp2)) begin
            miscompares++;
            $display("FAIL accel_below got %0d want %0d", MOUSE_X, exp2);
        end
        pkt(8'h18, 8'hF0, 8'h00);
        vectors++;
        if (MOUSE_X !== 8'(exp3)) begin
            miscompares++;
            $display("FAIL accel_neg16 got %0d want %0d", MOUSE_X, exp3);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        pkt(8'h08, 8'h0A, 8'h0A);
        send_byte(8'h08, 2'b00);
        send_byte(8'h05, 2'b00);
        do_reset();
        vectors++;
        if (MOUSE_X !== 8'd80 || MOUSE_Y !== 8'd60) begin
            miscompares++;
            $display("FAIL midreset_pos got x=%0d y=%0d want 80 60", MOUSE_X, MOUSE_Y);
        end
        pkt(8'h08, 8'h01, 8'h01);
        vectors++;
        if (MOUSE_X !== 8'd81 || MOUSE_Y !== 8'd61 || MOUSE_DX !== 8'h01) begin
            miscompares++;
            $display("FAIL midreset_next got x=%0d y=%0d dx=%h want 81 61 01", MOUSE_X, MOUSE_Y, MOUSE_DX);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_byte_error();
        test_sync();
        test_timeout();
        test_update_ignore();
        test_overflow();
        test_accel();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
